regfile_bypass_sb: RTL and testbench
====================================

Name: regfile_bypass_sb

Overview:
- Next-generation decode-stage register file for the pipelined CPU.
- NRD configurable read ports, each with full EX/ME/WB bypass plus bypass from a second, long-latency write-back port (mul/div unit).
- Generates the ID-stage stall: load-use hazards for configurable load latency, and a scoreboard of registers pending from multi-cycle ops.
- Register 0 is hard-wired to zero and is never forwarded or scoreboarded.

Parameters:
- XLEN, 32, data width.
- NREG, 32, register count (power of two); AW = log2(NREG).
- NRD, 2, number of read ports (1..4).
- LOAD_LAT, 1, load data cycles after EX before it is forwardable (1 or 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rd_en  in  NRD  read port i used by the ID instruction.
- rd_data  out  NRD*XLEN  read data after bypass.
- id_we  in  1  ID instruction writes a register through the main pipe.
- id_wa  in  AW  destination of the ID instruction.
- iss_long  in  1  ID instruction is a long-latency op.
- iss_rd  in  AW  destination of the long op.
- ex_we, ex_wa, ex_wd, ex_is_load  in  1/AW/XLEN/1  EX-stage write info.
- me_we, me_wa, me_wd, me_is_load  in  1/AW/XLEN/1  ME-stage write info.
- wb_we, wb_wa, wb_wd  in  1/AW/XLEN  main write-back port.
- lwb_we, lwb_wa, lwb_wd  in  1/AW/XLEN  long-op write-back port.
- stall  out  1  hold ID/IF and insert a bubble into EX.
- busy_vec  out  NREG  scoreboard state (registered).
- wr_conflict  out  1  registered flag: both write ports targeted the same address in one cycle.

Behaviour:
- Reset (rst=0 at a clk edge): all registers, busy_vec and wr_conflict become 0. Writes presented in the reset cycle are dropped.
- Read, per port, combinational:
  - Address 0 returns 0.
  - Otherwise priority: ex (ex_we && !ex_is_load), me (me_we && !(me_is_load && LOAD_LAT==2)), lwb, wb, array.
  - A stage matches only if its *_we is set and its *_wa equals the read address.
- Write, registered:
  - wb and lwb write the array at the clk edge; writes to address 0 are ignored.
  - Same nonzero address on both ports: wb wins, and wr_conflict=1 on the next cycle. wr_conflict otherwise returns to 0.
- Stall, combinational; 1 if any rd_en[i] port with nonzero address meets one of:
  - a) ex_is_load && ex_we && ex_wa==addr;
  - b) LOAD_LAT==2 && me_is_load && me_we && me_wa==addr;
  - c) busy_vec[addr]==1 and not (lwb_we && lwb_wa==addr), i.e. same-cycle bypass resolves it.
- Stall is also 1 on a WAW hazard:
  - id_we with busy_vec[id_wa], or
  - iss_long with busy_vec[iss_rd] (nonzero addresses), unless lwb clears that register this cycle.
- Scoreboard, registered:
  - Set busy[iss_rd] when iss_long && !stall && iss_rd!=0.
  - Clear busy[lwb_wa] when lwb_we.
  - Set and clear of the same register in one cycle: set wins.
  - lwb_we to a non-busy register: write occurs, busy unchanged.
- Latency: reads 0 cycles; array write visible via array one cycle after the write cycle (bypassed within the same cycle).

Decomposition:
- Shared package cpu_pkg: XLEN default, the zero-register constant, and the write-back stage record (we, wa, wd, is_load) typedef.
- One natural sub-module, rf_scoreboard: busy-bit array with set/clear/query and same-cycle clear-bypass. The read/bypass mux is instantiated per port with a generate loop.

Test Plan:
- Reset, then wb writes 0x1234 to r5; next cycle rd_addr0=5 -> rd_data0=0x1234, stall=0.
- ex_we=1, ex_wa=5, ex_wd=0xAAAA and me_wa=5, me_wd=0xBBBB; read r5 -> 0xAAAA (youngest wins). Read r0 while ex_wa=0 -> 0.
- Load-use: ex_is_load=1, ex_wa=7, rd_addr1=7, rd_en1=1 -> stall=1. Same with rd_en1=0 -> stall=0. LOAD_LAT=2 with me_is_load, me_wa=7 -> stall=1.
- Scoreboard:
  - iss_long with iss_rd=9 -> busy_vec[9]=1 next cycle; read r9 -> stall=1.
  - lwb_we with lwb_wa=9, lwb_wd=0x55 in a later cycle -> same cycle stall=0, rd_data=0x55; busy_vec[9]=0 next cycle.
- WAW and set-wins:
  - With busy[9]=1, id_we with id_wa=9 -> stall=1.
  - iss_long to r3 in the same cycle as lwb clears r3 -> busy_vec[3]=1 after the edge.
- Conflict and reset: wb and lwb both write r4 with 0x1 and 0x2 -> r4=0x1, wr_conflict=1 for one cycle. Assert rst=0 mid-run with busy bits set -> all busy bits and registers are 0 after the edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, the hard-wired zero register and
// the pipeline write-back stage record used by the register file bypass.
package cpu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int XLEN_MAX = 64;
    localparam int AW_MAX   = 8;
    localparam int ZERO_REG = 0;

    // Fields are sized to the widest supported configuration; narrower
    // instances zero-extend into them.
    typedef struct packed {
        logic                we;
        logic [AW_MAX-1:0]   wa;
        logic [XLEN_MAX-1:0] wd;
        logic                is_load;
    } wb_stage_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for registers awaiting a long-latency write-back.
// pend_vec masks out a register that the long write-back port clears this cycle.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy_vec,
    output logic [NREG-1:0] pend_vec
);

    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        clr_mask = '0;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        pend_vec = busy_vec & ~clr_mask;
    end

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        busy_nxt = pend_vec;
        if (set_en && set_addr != AW'(ZERO_REG)) busy_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_vec <= '0;
        else      busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Decode-stage register file with EX/ME/long-WB/WB bypass per read port,
// load-use and scoreboard stall generation, and dual write-back ports.
module regfile_bypass_sb
    import cpu_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = 32,
    parameter  int NRD      = 2,
    parameter  int LOAD_LAT = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic [NRD-1:0]      rd_en,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                id_we,
    input  logic [AW-1:0]       id_wa,
    input  logic                iss_long,
    input  logic [AW-1:0]       iss_rd,
    input  logic                ex_we,
    input  logic [AW-1:0]       ex_wa,
    input  logic [XLEN-1:0]     ex_wd,
    input  logic                ex_is_load,
    input  logic                me_we,
    input  logic [AW-1:0]       me_wa,
    input  logic [XLEN-1:0]     me_wd,
    input  logic                me_is_load,
    input  logic                wb_we,
    input  logic [AW-1:0]       wb_wa,
    input  logic [XLEN-1:0]     wb_wd,
    input  logic                lwb_we,
    input  logic [AW-1:0]       lwb_wa,
    input  logic [XLEN-1:0]     lwb_wd,
    output logic                stall,
    output logic [NREG-1:0]     busy_vec,
    output logic                wr_conflict
);

    localparam int unsigned NSTG = 4;

    logic [XLEN-1:0] rf [NREG];
    wb_stage_t       stg [NSTG];
    logic [NSTG-1:0] fwd;
    logic [NREG-1:0] pend_vec;
    logic [NRD-1:0]  port_haz;
    logic            waw_haz;
    logic            sb_set;

    // Index order is bypass priority: youngest producer first.
    always_comb begin
        stg[0] = '{we: ex_we,  wa: AW_MAX'(ex_wa),  wd: XLEN_MAX'(ex_wd),  is_load: ex_is_load};
        stg[1] = '{we: me_we,  wa: AW_MAX'(me_wa),  wd: XLEN_MAX'(me_wd),  is_load: me_is_load};
        stg[2] = '{we: lwb_we, wa: AW_MAX'(lwb_wa), wd: XLEN_MAX'(lwb_wd), is_load: 1'b0};
        stg[3] = '{we: wb_we,  wa: AW_MAX'(wb_wa),  wd: XLEN_MAX'(wb_wd),  is_load: 1'b0};
        fwd[0] = stg[0].we && !stg[0].is_load;
        fwd[1] = stg[1].we && !(stg[1].is_load && LOAD_LAT == 2);
        fwd[2] = stg[2].we && !stg[2].is_load;
        fwd[3] = stg[3].we && !stg[3].is_load;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            hit;

        always_comb begin
            a   = rd_addr[p*AW +: AW];
            d   = rf[a];
            hit = 1'b0;
            for (int unsigned s = 0; s < NSTG; s++) begin
                if (!hit && fwd[s] && stg[s].wa == AW_MAX'(a)) begin
                    d   = XLEN'(stg[s].wd);
                    hit = 1'b1;
                end
            end
            if (a == AW'(ZERO_REG)) d = '0;
        end

        assign rd_data[p*XLEN +: XLEN] = d;
        assign port_haz[p] = rd_en[p] && a != AW'(ZERO_REG) &&
                             ((ex_is_load && ex_we && ex_wa == a) ||
                              (LOAD_LAT == 2 && me_is_load && me_we && me_wa == a) ||
                              pend_vec[a]);
    end

    always_comb begin
        waw_haz = (id_we && id_wa != AW'(ZERO_REG) && pend_vec[id_wa]) ||
                  (iss_long && iss_rd != AW'(ZERO_REG) && pend_vec[iss_rd]);
        stall   = |port_haz || waw_haz;
        sb_set  = iss_long && !stall && iss_rd != AW'(ZERO_REG);
    end

    rf_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (iss_rd),
        .clr_en   (lwb_we),
        .clr_addr (lwb_wa),
        .busy_vec (busy_vec),
        .pend_vec (pend_vec)
    );

    // wb is written after lwb so it wins when both target the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (lwb_we && lwb_wa != AW'(ZERO_REG)) rf[lwb_wa] <= lwb_wd;
            if (wb_we && wb_wa != AW'(ZERO_REG))   rf[wb_wa]  <= wb_wd;
            wr_conflict <= wb_we && lwb_we && wb_wa == lwb_wa && wb_wa != AW'(ZERO_REG);
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Self-checking bench for regfile_bypass_sb; expectations are queued when
// stimulus is driven and popped when the outputs are sampled.
module tb_regfile_bypass_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_en;
    logic [NRD*XLEN-1:0] rd_data, rd_data2;
    logic                id_we, iss_long;
    logic [AW-1:0]       id_wa, iss_rd;
    logic                ex_we, ex_is_load, me_we, me_is_load, wb_we, lwb_we;
    logic [AW-1:0]       ex_wa, me_wa, wb_wa, lwb_wa;
    logic [XLEN-1:0]     ex_wd, me_wd, wb_wd, lwb_wd;
    logic                stall, stall2, wr_conflict, wr_conflict2;
    logic [NREG-1:0]     busy_vec, busy_vec2;

    logic [63:0] exp_q[$];
    logic [63:0] ev;
    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .LOAD_LAT(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .id_we(id_we), .id_wa(id_wa), .iss_long(iss_long), .iss_rd(iss_rd),
        .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
        .me_we(me_we), .me_wa(me_wa), .me_wd(me_wd), .me_is_load(me_is_load),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .lwb_we(lwb_we), .lwb_wa(lwb_wa), .lwb_wd(lwb_wd),
        .stall(stall), .busy_vec(busy_vec), .wr_conflict(wr_conflict)
    );

    regfile_bypass_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .LOAD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data2),
        .id_we(id_we), .id_wa(id_wa), .iss_long(iss_long), .iss_rd(iss_rd),
        .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
        .me_we(me_we), .me_wa(me_wa), .me_wd(me_wd), .me_is_load(me_is_load),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .lwb_we(lwb_we), .lwb_wa(lwb_wa), .lwb_wd(lwb_wd),
        .stall(stall2), .busy_vec(busy_vec2), .wr_conflict(wr_conflict2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        rd_addr = '0; rd_en = '0;
        id_we = 1'b0; id_wa = '0; iss_long = 1'b0; iss_rd = '0;
        ex_we = 1'b0; ex_wa = '0; ex_wd = '0; ex_is_load = 1'b0;
        me_we = 1'b0; me_wa = '0; me_wd = '0; me_is_load = 1'b0;
        wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        lwb_we = 1'b0; lwb_wa = '0; lwb_wd = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        rd_addr[4:0] = 5'd5; rd_en = 2'b01;
        exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (busy_vec !== ev[NREG-1:0]) $display("FAIL reset_busy: got %h want %h", busy_vec, ev[NREG-1:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (wr_conflict !== ev[0]) $display("FAIL reset_conflict: got %b want %b", wr_conflict, ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL reset_stall: got %b want %b", stall, ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL reset_rd0: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (busy_vec2 !== ev[NREG-1:0]) $display("FAIL reset_busy2: got %h want %h", busy_vec2, ev[NREG-1:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (wr_conflict2 !== ev[0]) $display("FAIL reset_conflict2: got %b want %b", wr_conflict2, ev[0]); else n_pass++;
    endtask

    task automatic test_read_write();
        cyc(); idle();
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h1234;
        rd_addr[4:0] = 5'd5; rd_en = 2'b01;
        exp_q.push_back(64'h1234);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL wb_bypass: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        cyc();
        wb_we = 1'b0; wb_wd = '0;
        exp_q.push_back(64'h1234); exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL array_read: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL array_stall: got %b want %b", stall, ev[0]); else n_pass++;
    endtask

    task automatic test_bypass_priority();
        cyc(); idle();
        rd_addr[4:0] = 5'd5; rd_en = 2'b01;
        ex_we = 1'b1; ex_wa = 5'd5; ex_wd = 32'hAAAA;
        me_we = 1'b1; me_wa = 5'd5; me_wd = 32'hBBBB;
        exp_q.push_back(64'hAAAA);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL ex_priority: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        cyc();
        ex_we = 1'b0;
        exp_q.push_back(64'hBBBB);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL me_bypass: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        cyc();
        me_we = 1'b0;
        ex_we = 1'b1; ex_wa = 5'd0; ex_wd = 32'hFFFF;
        rd_addr[4:0] = 5'd0;
        exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL r0_zero: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
    endtask

    task automatic test_load_use();
        cyc(); idle();
        ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd7; ex_wd = 32'hDEAD;
        rd_addr[9:5] = 5'd7; rd_en = 2'b10;
        exp_q.push_back(64'h1); exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL load_use_stall: got %b want %b", stall, ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[63:32] !== ev[31:0]) $display("FAIL ex_load_no_fwd: got %h want %h", rd_data[63:32], ev[31:0]); else n_pass++;
        cyc();
        rd_en = 2'b00;
        exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL load_unused_port: got %b want %b", stall, ev[0]); else n_pass++;
        cyc();
        ex_we = 1'b0; ex_is_load = 1'b0;
        me_we = 1'b1; me_is_load = 1'b1; me_wa = 5'd7; me_wd = 32'h77;
        rd_en = 2'b10;
        exp_q.push_back(64'h0); exp_q.push_back(64'h77);
        exp_q.push_back(64'h1); exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL me_load_lat1_stall: got %b want %b", stall, ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[63:32] !== ev[31:0]) $display("FAIL me_load_lat1_fwd: got %h want %h", rd_data[63:32], ev[31:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (stall2 !== ev[0]) $display("FAIL me_load_lat2_stall: got %b want %b", stall2, ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data2[63:32] !== ev[31:0]) $display("FAIL me_load_lat2_nofwd: got %h want %h", rd_data2[63:32], ev[31:0]); else n_pass++;
    endtask

    task automatic test_scoreboard();
        cyc(); idle();
        iss_long = 1'b1; iss_rd = 5'd9;
        exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL issue_stall: got %b want %b", stall, ev[0]); else n_pass++;
        cyc();
        iss_long = 1'b0;
        rd_addr[4:0] = 5'd9; rd_en = 2'b01;
        exp_q.push_back(64'h1); exp_q.push_back(64'h1);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (busy_vec[9] !== ev[0]) $display("FAIL busy9_set: got %b want %b", busy_vec[9], ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL busy_read_stall: got %b want %b", stall, ev[0]); else n_pass++;
        cyc();
        lwb_we = 1'b1; lwb_wa = 5'd9; lwb_wd = 32'h55;
        exp_q.push_back(64'h0); exp_q.push_back(64'h55);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL lwb_clear_stall: got %b want %b", stall, ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL lwb_bypass: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        cyc();
        lwb_we = 1'b0; lwb_wd = '0;
        exp_q.push_back(64'h0); exp_q.push_back(64'h55);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (busy_vec[9] !== ev[0]) $display("FAIL busy9_clear: got %b want %b", busy_vec[9], ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL lwb_array: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
    endtask

    task automatic test_waw();
        cyc(); idle();
        iss_long = 1'b1; iss_rd = 5'd9;
        cyc(); idle();
        id_we = 1'b1; id_wa = 5'd9;
        exp_q.push_back(64'h1);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL waw_id_stall: got %b want %b", stall, ev[0]); else n_pass++;
        cyc(); idle();
        iss_long = 1'b1; iss_rd = 5'd3;
        lwb_we = 1'b1; lwb_wa = 5'd3; lwb_wd = 32'h3;
        exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL set_clr_stall: got %b want %b", stall, ev[0]); else n_pass++;
        cyc(); idle();
        iss_long = 1'b1; iss_rd = 5'd9;
        lwb_we = 1'b1; lwb_wa = 5'd9; lwb_wd = 32'h99;
        exp_q.push_back(64'h1); exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (busy_vec[3] !== ev[0]) $display("FAIL set_wins_r3: got %b want %b", busy_vec[3], ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (stall !== ev[0]) $display("FAIL waw_lwb_resolves: got %b want %b", stall, ev[0]); else n_pass++;
        cyc(); idle();
        exp_q.push_back(64'h1);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (busy_vec[9] !== ev[0]) $display("FAIL set_wins_r9: got %b want %b", busy_vec[9], ev[0]); else n_pass++;
    endtask

    task automatic test_conflict();
        cyc(); idle();
        wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h1;
        lwb_we = 1'b1; lwb_wa = 5'd4; lwb_wd = 32'h2;
        rd_addr[4:0] = 5'd4; rd_en = 2'b01;
        exp_q.push_back(64'h2); exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL lwb_over_wb_read: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (wr_conflict !== ev[0]) $display("FAIL conflict_early: got %b want %b", wr_conflict, ev[0]); else n_pass++;
        cyc();
        wb_we = 1'b0; lwb_we = 1'b0;
        exp_q.push_back(64'h1); exp_q.push_back(64'h1);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (wr_conflict !== ev[0]) $display("FAIL conflict_flag: got %b want %b", wr_conflict, ev[0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL wb_wins_write: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        cyc();
        exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (wr_conflict !== ev[0]) $display("FAIL conflict_clear: got %b want %b", wr_conflict, ev[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        cyc(); idle();
        rst = 1'b0;
        wb_we = 1'b1; wb_wa = 5'd10; wb_wd = 32'hDEAD;
        iss_long = 1'b1; iss_rd = 5'd12;
        cyc(); idle();
        rst = 1'b1;
        rd_addr[4:0] = 5'd4; rd_addr[9:5] = 5'd10;
        exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        mid();
        ev = exp_q.pop_front(); n_tot++;
        if (busy_vec !== ev[NREG-1:0]) $display("FAIL midreset_busy: got %h want %h", busy_vec, ev[NREG-1:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[31:0] !== ev[31:0]) $display("FAIL midreset_r4: got %h want %h", rd_data[31:0], ev[31:0]); else n_pass++;
        ev = exp_q.pop_front(); n_tot++;
        if (rd_data[63:32] !== ev[31:0]) $display("FAIL midreset_write_dropped: got %h want %h", rd_data[63:32], ev[31:0]); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_read_write();
        test_bypass_priority();
        test_load_use();
        test_scoreboard();
        test_waw();
        test_conflict();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
